// File: rtl/wb_data_if.sv
// wb_data_if: Wishbone master adapter for the core's data-memory port.
// Turns each ce-qualified request into one classic Wishbone cycle.
// It holds the pipeline with stallreq_o until the slave acks or the watchdog aborts.
// After an ack, it keeps load data visible while other units still stall the pipeline.
module wb_data_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o
);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BUSY           = 2'd1,
        WAIT_FOR_STALL = 2'd2
    } state_t;

    // Watchdog value seen in the TIMEOUT-th BUSY cycle (counter starts at 0).
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_wb_addr;
    logic [31:0] r_wb_data;
    logic        r_wb_we;
    logic [3:0]  r_wb_sel;
    logic        r_wb_stb;
    logic        r_wb_cyc;
    logic        r_bus_err;
    logic [31:0] r_rd_buf;
    logic [15:0] r_wdog;

    logic        w_stalled;
    logic        w_ack;
    logic        w_timeout;
    logic        w_stallreq;
    logic [31:0] w_cpu_data;

    assign w_stalled = |stall_i;
    assign w_ack     = (r_state == BUSY) && wb_ack_i;
    // An ack in the same cycle takes priority over the watchdog abort.
    assign w_timeout = (r_state == BUSY) && !wb_ack_i && (r_wdog == WDOG_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, stall request and load-data return path.
    always_comb begin
        w_state_next = r_state;
        w_stallreq   = 1'b0;
        w_cpu_data   = 32'd0;
        case (r_state)
            IDLE: begin
                w_stallreq = cpu_ce_i;
                if (cpu_ce_i) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_ack || w_timeout) begin
                    w_state_next = w_stalled ? WAIT_FOR_STALL : IDLE;
                    if (w_ack && !r_wb_we) begin
                        w_cpu_data = wb_data_i;
                    end
                end else begin
                    w_stallreq = 1'b1;
                end
            end
            WAIT_FOR_STALL: begin
                w_cpu_data = r_rd_buf;
                if (!w_stalled) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Bus registers, read buffer, watchdog and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_addr <= 32'd0;
            r_wb_data <= 32'd0;
            r_wb_we   <= 1'b0;
            r_wb_sel  <= 4'd0;
            r_wb_stb  <= 1'b0;
            r_wb_cyc  <= 1'b0;
            r_bus_err <= 1'b0;
            r_rd_buf  <= 32'd0;
            r_wdog    <= 16'd0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_ce_i) begin
                        r_wb_addr <= cpu_addr_i;
                        r_wb_data <= cpu_data_i;
                        r_wb_we   <= cpu_we_i;
                        r_wb_sel  <= cpu_sel_i;
                        r_wb_stb  <= 1'b1;
                        r_wb_cyc  <= 1'b1;
                        r_wdog    <= 16'd0;
                    end
                end
                BUSY: begin
                    r_wdog <= r_wdog + 16'd1;
                    if (w_ack || w_timeout) begin
                        r_wb_addr <= 32'd0;
                        r_wb_data <= 32'd0;
                        r_wb_we   <= 1'b0;
                        r_wb_sel  <= 4'd0;
                        r_wb_stb  <= 1'b0;
                        r_wb_cyc  <= 1'b0;
                        // Writes and aborted cycles leave zero in the buffer.
                        r_rd_buf  <= (w_ack && !r_wb_we) ? wb_data_i : 32'd0;
                        r_bus_err <= w_timeout;
                    end
                end
                default: begin
                    // WAIT_FOR_STALL holds the read buffer unchanged.
                end
            endcase
        end
    end

    assign wb_addr_o  = r_wb_addr;
    assign wb_data_o  = r_wb_data;
    assign wb_we_o    = r_wb_we;
    assign wb_sel_o   = r_wb_sel;
    assign wb_stb_o   = r_wb_stb;
    assign wb_cyc_o   = r_wb_cyc;
    assign bus_err_o  = r_bus_err;
    // Combinational outputs are forced low while reset is asserted.
    // This keeps a pending cpu_ce_i from raising a stall during reset.
    assign stallreq_o = w_stallreq & ~rst;
    assign cpu_data_o = rst ? 32'd0 : w_cpu_data;

endmodule

// File: tb/tb_wb_data_if.sv
// Testbench for wb_data_if.
// It applies a table of directed accesses, then randomized accesses.
// Each access is checked against a transaction-level model of the bus protocol.
module tb_wb_data_if;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic berr_exp = 1'b0;

    wb_data_if #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .bus_err_o  (bus_err_o),
        .wb_data_i  (wb_data_i),
        .wb_ack_i   (wb_ack_i),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          ack_lat;   // BUSY cycle index carrying the ack (>TO: never)
        int          stall_n;   // cycles the pipeline stays frozen after the ack
        logic [31:0] rdata;
        int          gap;       // idle cycles after the access
        logic        spur;      // spurious ack during those idle cycles
        logic [31:0] exp_data;  // load data expected in the terminating cycle
    } vec_t;

    vec_t vtab[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Bus outputs should be idle, and bus_err should match the pending expectation.
    task automatic chk_bus_idle(input string tag);
        chk({tag, "_cyc"},  wb_cyc_o,  0);
        chk({tag, "_stb"},  wb_stb_o,  0);
        chk({tag, "_we"},   wb_we_o,   0);
        chk({tag, "_addr"}, wb_addr_o, 0);
        chk({tag, "_wdat"}, wb_data_o, 0);
        chk({tag, "_sel"},  wb_sel_o,  0);
        chk({tag, "_berr"}, bus_err_o, berr_exp);
        berr_exp = 1'b0;
    endtask

    task automatic idle_cyc(input logic spur);
        cpu_ce_i   = 1'b0;
        cpu_addr_i = $urandom;
        wb_ack_i   = spur;
        wb_data_i  = $urandom;
        stall_i    = 6'($urandom);
        @(negedge clk);
        chk("idle_stallreq", stallreq_o, 0);
        chk("idle_cpu_data", cpu_data_o, 0);
        chk_bus_idle("idle");
        @(posedge clk); #1;
    endtask

    // One access, starting with the request cycle in IDLE.
    // The model follows the protocol rules in time:
    // - The access ends at BUSY cycle min(ack_lat, TO).
    // - It is aborted if ack_lat > TO.
    // - It then stays frozen for stall_n cycles.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input int ack_lat, input int stall_n,
                          input logic [31:0] rdata, output logic [31:0] got_data);
        logic        to;
        int          fin;
        logic [31:0] exp_ret;
        to       = (ack_lat > int'(TO));
        fin      = to ? int'(TO) : ack_lat;
        exp_ret  = (to || we) ? 32'd0 : rdata;
        got_data = 32'hx;
        // Request cycle.
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = data;
        cpu_sel_i  = sel;
        stall_i    = 6'd0;
        wb_ack_i   = 1'b0;
        wb_data_i  = $urandom;
        @(negedge clk);
        chk("req_stallreq", stallreq_o, 1);
        chk("req_cpu_data", cpu_data_o, 0);
        chk_bus_idle("req");
        @(posedge clk); #1;
        // BUSY cycles; cpu inputs are scrambled and must be ignored.
        for (int k = 1; k <= fin; k++) begin
            cpu_ce_i   = 1'($urandom_range(0, 1));
            cpu_we_i   = 1'($urandom_range(0, 1));
            cpu_addr_i = $urandom;
            cpu_data_i = $urandom;
            cpu_sel_i  = 4'($urandom);
            wb_ack_i   = (k == ack_lat);
            wb_data_i  = (k == ack_lat) ? rdata : $urandom;
            if (k == fin) stall_i = (stall_n > 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            else          stall_i = 6'($urandom);
            @(negedge clk);
            chk("busy_cyc",  wb_cyc_o,  1);
            chk("busy_stb",  wb_stb_o,  1);
            chk("busy_addr", wb_addr_o, addr);
            chk("busy_wdat", wb_data_o, data);
            chk("busy_we",   wb_we_o,   we);
            chk("busy_sel",  wb_sel_o,  sel);
            chk("busy_berr", bus_err_o, 0);
            chk("busy_stallreq", stallreq_o, (k == fin) ? 0 : 1);
            chk("busy_cpu_data", cpu_data_o, (k == fin) ? exp_ret : 32'd0);
            if (k == fin) got_data = cpu_data_o;
            @(posedge clk); #1;
        end
        berr_exp = to;
        // Frozen-pipeline cycles: load data held, no stall request.
        for (int w = 1; w <= stall_n; w++) begin
            cpu_ce_i  = 1'($urandom_range(0, 1));
            wb_ack_i  = 1'($urandom_range(0, 1));
            wb_data_i = $urandom;
            stall_i   = (w < stall_n) ? 6'($urandom_range(1, 63)) : 6'd0;
            @(negedge clk);
            chk("wait_stallreq", stallreq_o, 0);
            chk("wait_cpu_data", cpu_data_o, exp_ret);
            chk_bus_idle("wait");
            @(posedge clk); #1;
        end
        cpu_ce_i = 1'b0;
        wb_ack_i = 1'b0;
        $display("txn we=%0d addr=%h wdata=%h sel=%h ack_lat=%0d stall=%0d timeout=%0d ret=%h",
                 we, addr, data, sel, ack_lat, stall_n, to, got_data);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] got;
        vtab[0] = '{1'b0, 32'h0000_0100, 32'h0,         4'b1111, 3,  0, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF};
        vtab[1] = '{1'b1, 32'h0000_0104, 32'h1234_5678, 4'b0011, 1,  0, 32'hFFFF_FFFF, 1, 1'b0, 32'h0};
        vtab[2] = '{1'b0, 32'h0000_0200, 32'h0,         4'b1111, 2,  3, 32'hA5A5_0001, 1, 1'b0, 32'hA5A5_0001};
        vtab[3] = '{1'b0, 32'h0000_0300, 32'h0,         4'b1111, 99, 0, 32'h5555_AAAA, 1, 1'b0, 32'h0};
        vtab[4] = '{1'b0, 32'h0000_0304, 32'h0,         4'b0110, 4,  0, 32'h0BAD_F00D, 0, 1'b0, 32'h0BAD_F00D};
        vtab[5] = '{1'b0, 32'h0000_0400, 32'h0,         4'b1111, 1,  0, 32'h1111_1111, 0, 1'b0, 32'h1111_1111};
        vtab[6] = '{1'b0, 32'h0000_0404, 32'h0,         4'b1111, 1,  0, 32'h2222_2222, 2, 1'b1, 32'h2222_2222};
        vtab[7] = '{1'b1, 32'h0000_0500, 32'hCAFE_BABE, 4'b1100, 9,  2, 32'h7777_7777, 1, 1'b0, 32'h0};

        rst = 1'b1; stall_i = 6'd0; cpu_ce_i = 1'b0; cpu_addr_i = 32'd0; cpu_data_i = 32'd0;
        cpu_we_i = 1'b0; cpu_sel_i = 4'd0; wb_data_i = 32'd0; wb_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stallreq", stallreq_o, 0);
        chk("rst_cpu_data", cpu_data_o, 0);
        chk_bus_idle("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cyc(1'b1);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            do_txn(vtab[i].we, vtab[i].addr, vtab[i].data, vtab[i].sel,
                   vtab[i].ack_lat, vtab[i].stall_n, vtab[i].rdata, got);
            chk("tbl_ret_data", got, vtab[i].exp_data);
            for (int g = 0; g < vtab[i].gap; g++) idle_cyc(vtab[i].spur);
        end

        // Asynchronous reset in the middle of a BUSY cycle.
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0800; cpu_sel_i = 4'hF;
        cpu_data_i = 32'h0; stall_i = 6'd0; wb_ack_i = 1'b0;
        @(posedge clk); #1;
        cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_stb", wb_stb_o, 1);
        chk("pre_rst_stallreq", stallreq_o, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_stallreq", stallreq_o, 0);
        chk("async_rst_cpu_data", cpu_data_o, 0);
        chk_bus_idle("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cyc(1'b1);
        do_txn(1'b0, 32'h0000_0900, 32'h0, 4'hF, 2, 1, 32'h0600_D001, got);
        chk("post_rst_ret", got, 32'h0600_D001);

        // Randomized accesses.
        for (int t = 0; t < 60; t++) begin
            logic        we;
            logic [31:0] rd;
            int          gap;
            we  = 1'($urandom_range(0, 1));
            rd  = $urandom;
            do_txn(we, $urandom, $urandom, 4'($urandom), $urandom_range(1, 6),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, rd, got);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cyc(1'($urandom_range(0, 1)));
        end
        idle_cyc(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
